wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter for the LM32 SoC.
- Shares a single slave port between the LM32 instruction and data buses, or any two bus masters. Typical use: a single-ported peripheral or memory controller that must not sit behind two separate conbus paths.
- Round-robin grant, held for the whole cyc of a transaction.
- Optional watchdog terminates hung slave cycles with an error.

Parameters:
- adr_width, 32, address bus width in bits.
- dat_width, 32, data bus width in bits; sel width is dat_width/8.
- timeout_cycles, 255, stalled-strobe cycles before the watchdog fires (watchdog build only); legal range 2..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active high
- m0_adr_i  in  adr_width  master0 address
- m0_dat_i  in  dat_width  master0 write data
- m0_dat_o  out  dat_width  master0 read data
- m0_sel_i  in  dat_width/8  master0 byte select
- m0_we_i  in  1  master0 write enable
- m0_cyc_i  in  1  master0 cycle
- m0_stb_i  in  1  master0 strobe
- m0_ack_o  out  1  master0 acknowledge
- m0_err_o  out  1  master0 error
- m1_*  same set as m0, for master1
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  out  slave request, widths as the m0 equivalents
- s_dat_i  in  dat_width  slave read data
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot current grant {m1,m0}; 00 when idle

Behaviour:
- State machine, three states:
  - IDLE: slave port idle; picks the next master to grant.
  - GNT0: m0 owns the slave port.
  - GNT1: m1 owns the slave port.
- Reset values:
  - state=IDLE, last=1, gnt_o=00.
  - s_cyc_o=s_stb_o=s_we_o=0; s_adr_o, s_dat_o, s_sel_o =0.
  - m*_ack_o=m*_err_o=0; m*_dat_o=0.
  - Watchdog counter=0.
- Reset is synchronous and dominates everything. Reset mid-transaction drops grant and s_cyc_o on the next edge; no ack or err is issued for the aborted cycle.
- Transitions out of IDLE:
  - Only m0_cyc_i=1 → GNT0.
  - Only m1_cyc_i=1 → GNT1.
  - Both =1 → grant the master not equal to `last`. After reset, m0 wins first.
- GNTx → IDLE on the edge where mx_cyc_i=0. `last` updates to x at that point.
- The other master's cyc is ignored while GNTx; the grant is never pre-empted. Multi-beat and RMW sequences under a held cyc stay atomic.
- Grant latency: one clk from cyc assertion in IDLE. There is one IDLE cycle between consecutive grants.
- Slave-side routing in GNTx (combinational from the state register):
  - s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o = master x's signals.
  - s_cyc_o = mx_cyc_i.
  - In IDLE, s_cyc_o=s_stb_o=0.
- Master-side routing:
  - mx_ack_o = s_ack_i & grant_x.
  - mx_dat_o = s_dat_i when granted, else 0.
  - The non-granted master sees ack=0 and err=0.
- mx_cyc_i dropping in the same cycle as s_ack_i: the ack is still forwarded that cycle, then the block goes to IDLE.
- No arithmetic on the data path. gnt_o always equals the state encoding.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit counter increments each clk while granted & s_stb_o & ~s_ack_i.
  - Counter clears on s_ack_i, on any state change, and on reset.
  - When counter = timeout_cycles-1 and no ack: mx_err_o=1 for exactly one cycle, and s_cyc_o/s_stb_o are forced 0 that same cycle.
  - The counter clears and the grant is kept until the master drops cyc.
  - If s_ack_i and the timeout coincide, ack wins and no err is issued.
- Undefined: no counter is synthesized and m0_err_o=m1_err_o=0 constantly.

Test Plan:
- Reset, then m0 cyc/stb write to adr 0x00000010, data 0xDEADBEEF, slave acks after 2 cycles → gnt_o=01 one cycle after cyc; slave sees exactly that adr/data/sel; m0_ack_o pulses once; m1_ack_o stays 0.
- m0 and m1 assert cyc on the same cycle from reset → m0 granted first. m0 drops cyc after its ack → one IDLE cycle, then gnt_o=10. Repeat the simultaneous request → m0 granted (alternation holds).
- m1 granted and holding cyc across 3 ack'd beats while m0 requests → m0 is not granted until m1 deasserts cyc; gnt_o never shows 11.
- Read: m1 reads, slave returns 0x12345678 with ack → m1_dat_o=0x12345678 on the ack cycle; m0_dat_o=0.
- Reset asserted while GNT0 with a pending stb → next edge: gnt_o=00, s_cyc_o=0, no ack or err to m0.
- With WB_ARB_TIMEOUT_EN and timeout_cycles=8, the slave never acks a strobe → m0_err_o=1 for one cycle after 8 stalled cycles, with s_stb_o=0 that cycle. Without the macro the same stimulus hangs with err=0.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant held for the whole cyc of a transaction.
// Define WB_ARB_TIMEOUT_EN to build the stalled-strobe watchdog driven by parameter timeout_cycles.
module wb_arbiter2 #(
   parameter int adr_width      = 32,
   parameter int dat_width      = 32,
   parameter int timeout_cycles = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [adr_width-1:0]   m0_adr_i,
   input  logic [dat_width-1:0]   m0_dat_i,
   output logic [dat_width-1:0]   m0_dat_o,
   input  logic [dat_width/8-1:0] m0_sel_i,
   input  logic                   m0_we_i,
   input  logic                   m0_cyc_i,
   input  logic                   m0_stb_i,
   output logic                   m0_ack_o,
   output logic                   m0_err_o,
   input  logic [adr_width-1:0]   m1_adr_i,
   input  logic [dat_width-1:0]   m1_dat_i,
   output logic [dat_width-1:0]   m1_dat_o,
   input  logic [dat_width/8-1:0] m1_sel_i,
   input  logic                   m1_we_i,
   input  logic                   m1_cyc_i,
   input  logic                   m1_stb_i,
   output logic                   m1_ack_o,
   output logic                   m1_err_o,
   output logic [adr_width-1:0]   s_adr_o,
   output logic [dat_width-1:0]   s_dat_o,
   output logic [dat_width/8-1:0] s_sel_o,
   output logic                   s_we_o,
   output logic                   s_cyc_o,
   output logic                   s_stb_o,
   input  logic [dat_width-1:0]   s_dat_i,
   input  logic                   s_ack_i,
   output logic [1:0]             gnt_o
);

   // The state encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } stateT;

   stateT rState;
   logic  rLast;
   logic  wErr;

   // rLast remembers who was served most recently so a simultaneous request goes to the other master.
   always_ff @(posedge clk) begin
      if (reset) begin
         rState <= IDLE;
         rLast  <= 1'b1;
      end else begin
         case (rState)
            IDLE: begin
               if (m0_cyc_i && m1_cyc_i)
                  rState <= rLast ? GNT0 : GNT1;
               else if (m0_cyc_i)
                  rState <= GNT0;
               else if (m1_cyc_i)
                  rState <= GNT1;
            end
            GNT0: begin
               if (!m0_cyc_i) begin
                  rState <= IDLE;
                  rLast  <= 1'b0;
               end
            end
            GNT1: begin
               if (!m1_cyc_i) begin
                  rState <= IDLE;
                  rLast  <= 1'b1;
               end
            end
            default: rState <= IDLE;
         endcase
      end
   end

   assign gnt_o = rState;

`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(timeout_cycles - 1);

   logic [15:0] rWdog;
   logic        wGranted;
   logic        wStb;
   logic        wLeave;

   // An ack in the terminal cycle takes priority over the timeout.
   assign wGranted = (rState == GNT0) || (rState == GNT1);
   assign wStb     = ((rState == GNT0) && m0_stb_i) || ((rState == GNT1) && m1_stb_i);
   assign wLeave   = ((rState == GNT0) && !m0_cyc_i) || ((rState == GNT1) && !m1_cyc_i);
   assign wErr     = wGranted && wStb && !s_ack_i && (rWdog == WD_LAST);

   // Watchdog counts stalled strobe cycles and clears on ack, state change, error or reset.
   always_ff @(posedge clk) begin
      if (reset)
         rWdog <= '0;
      else if (s_ack_i || wLeave || wErr)
         rWdog <= '0;
      else if (wGranted && wStb)
         rWdog <= rWdog + 16'd1;
   end
`else
   assign wErr = 1'b0;
`endif

   // Routes the granted master to the slave; a watchdog error also masks the slave request for that cycle.
   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      case (rState)
         GNT0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i && !wErr;
            s_stb_o  = m0_stb_i && !wErr;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = wErr;
         end
         GNT1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i && !wErr;
            s_stb_o  = m1_stb_i && !wErr;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = wErr;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed grant/routing cases plus randomized two-master traffic against a scoreboard.
// The DUT is built with timeout_cycles=8; with WB_ARB_TIMEOUT_EN defined the watchdog is checked.
module tb_wb_arbiter2;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] rdata;
   } beatT;

   localparam int TIMEOUT = 8;

   logic        clk;
   logic        reset;
   logic [31:0] mAdrI [2];
   logic [31:0] mDatI [2];
   logic [3:0]  mSelI [2];
   logic        mWeI  [2];
   logic        mCycI [2];
   logic        mStbI [2];
   logic [31:0] mDatO [2];
   logic        mAck  [2];
   logic        mErr  [2];
   logic [31:0] sAdr, sDatO, sDatI;
   logic [3:0]  sSel;
   logic        sWe, sCyc, sStb, sAck;
   logic [1:0]  gnt;

   int          nChecks = 0;
   int          nFails  = 0;
   beatT        expQ0[$];
   beatT        expQ1[$];
   int          ackLog[$];
   int          logBase = 0;
   logic [31:0] shadow [128];
   logic        slaveHang  = 1'b0;
   logic        errAllowed = 1'b0;
   int          fixedWait  = -1;

   wb_arbiter2 #(.adr_width(32), .dat_width(32), .timeout_cycles(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .m0_adr_i(mAdrI[0]), .m0_dat_i(mDatI[0]), .m0_dat_o(mDatO[0]), .m0_sel_i(mSelI[0]),
      .m0_we_i(mWeI[0]), .m0_cyc_i(mCycI[0]), .m0_stb_i(mStbI[0]), .m0_ack_o(mAck[0]), .m0_err_o(mErr[0]),
      .m1_adr_i(mAdrI[1]), .m1_dat_i(mDatI[1]), .m1_dat_o(mDatO[1]), .m1_sel_i(mSelI[1]),
      .m1_we_i(mWeI[1]), .m1_cyc_i(mCycI[1]), .m1_stb_i(mStbI[1]), .m1_ack_o(mAck[1]), .m1_err_o(mErr[1]),
      .s_adr_o(sAdr), .s_dat_o(sDatO), .s_sel_o(sSel), .s_we_o(sWe), .s_cyc_o(sCyc), .s_stb_o(sStb),
      .s_dat_i(sDatI), .s_ack_i(sAck), .gnt_o(gnt)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global watchdog so a hung bench still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Slave: acks each new beat after 0..2 wait cycles (or fixedWait), backed by a word memory.
   initial begin : slaveModel
      int          waitLeft;
      logic        inBeat;
      logic [6:0]  idx;
      logic [31:0] mem [128];
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      waitLeft = 0;
      inBeat   = 1'b0;
      sAck     = 1'b0;
      sDatI    = 32'hA5A5_A5A5;
      forever begin
         @(posedge clk);
         #1;
         sAck  = 1'b0;
         sDatI = $urandom();
         if (reset || !sCyc || !sStb || slaveHang) begin
            inBeat = 1'b0;
         end else begin
            if (!inBeat) begin
               inBeat   = 1'b1;
               waitLeft = (fixedWait >= 0) ? fixedWait : $urandom_range(0, 2);
            end
            if (waitLeft == 0) begin
               idx  = sAdr[8:2];
               sAck = 1'b1;
               if (sWe) mem[idx] = mergeBytes(mem[idx], sDatO, sSel);
               else     sDatI = mem[idx];
               inBeat = 1'b0;
            end else begin
               waitLeft--;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every master ack and checks what the slave saw.
   initial begin : monitor
      beatT e;
      int   y;
      logic haveExp;
      forever begin
         @(negedge clk);
         if (!reset) begin
            checkOutput("gnt_never_both", 32'(gnt == 2'b11), 32'd0);
            for (int x = 0; x < 2; x++) begin
               y = 1 - x;
               if (mAck[x]) begin
                  ackLog.push_back(x);
                  haveExp = (x == 0) ? (expQ0.size() != 0) : (expQ1.size() != 0);
                  if (!haveExp) begin
                     nChecks++;
                     nFails++;
                     $display("[TB] FAIL unexpected_ack: master %0d acked with empty queue", x);
                  end else begin
                     if (x == 0) e = expQ0.pop_front();
                     else        e = expQ1.pop_front();
                     checkOutput("ack_gnt", 32'(gnt), 32'(1 << x));
                     checkOutput("slave_adr", sAdr, e.adr);
                     checkOutput("slave_we", 32'(sWe), 32'(e.we));
                     checkOutput("slave_sel", 32'(sSel), 32'(e.sel));
                     if (e.we) checkOutput("slave_wdata", sDatO, e.dat);
                     else      checkOutput("master_rdata", mDatO[x], e.rdata);
                     checkOutput("other_ack", 32'(mAck[y]), 32'd0);
                     checkOutput("other_dat", mDatO[y], 32'd0);
                     checkOutput("other_err", 32'(mErr[y]), 32'd0);
                  end
               end
               if (mErr[x] && !errAllowed) begin
                  nChecks++;
                  nFails++;
                  $display("[TB] FAIL unexpected_err: master %0d err=1", x);
               end
            end
         end
      end
   end

   // One master transaction of nBeats consecutive words under a single cyc.
   task automatic applyStimulus(input int x, input int nBeats, input logic [31:0] baseAdr,
                                input logic we, input logic [31:0] dat, input logic [3:0] sel);
      beatT       b;
      logic [6:0] idx;
      int         guard;
      mCycI[x] = 1'b1;
      for (int i = 0; i < nBeats; i++) begin
         b.adr = baseAdr + 32'(4 * i);
         b.we  = we;
         b.dat = dat + 32'(i);
         b.sel = sel;
         idx   = b.adr[8:2];
         if (we) shadow[idx] = mergeBytes(shadow[idx], b.dat, sel);
         b.rdata = shadow[idx];
         if (x == 0) expQ0.push_back(b);
         else        expQ1.push_back(b);
         mAdrI[x] = b.adr;
         mDatI[x] = b.dat;
         mSelI[x] = sel;
         mWeI[x]  = we;
         mStbI[x] = 1'b1;
         guard = 0;
         @(negedge clk);
         while (!mAck[x] && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         checkOutput("ack_wait", 32'(mAck[x]), 32'd1);
         #1;
      end
      mStbI[x] = 1'b0;
      mCycI[x] = 1'b0;
      mWeI[x]  = 1'b0;
   endtask

   task automatic checkAckOrder(input string name, input int n, input logic [7:0] pattern);
      checkOutput("ack_count", 32'(ackLog.size() - logBase), 32'(n));
      for (int i = 0; i < n && (logBase + i) < ackLog.size(); i++)
         checkOutput(name, 32'(ackLog[logBase + i]), 32'(pattern[i]));
      logBase = ackLog.size();
   endtask

   task automatic checkResetState();
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_s_cyc", 32'(sCyc), 32'd0);
      checkOutput("rst_s_stb", 32'(sStb), 32'd0);
      checkOutput("rst_s_we", 32'(sWe), 32'd0);
      checkOutput("rst_s_adr", sAdr, 32'd0);
      checkOutput("rst_s_dat", sDatO, 32'd0);
      checkOutput("rst_s_sel", 32'(sSel), 32'd0);
      for (int x = 0; x < 2; x++) begin
         checkOutput("rst_m_ack", 32'(mAck[x]), 32'd0);
         checkOutput("rst_m_err", 32'(mErr[x]), 32'd0);
         checkOutput("rst_m_dat", mDatO[x], 32'd0);
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkResetState();
      #1 reset = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Watches a simultaneous request: m0 first, exactly one idle cycle, then m1.
   task automatic watchHandover();
      int guard;
      int idleCnt;
      @(negedge clk);
      checkOutput("simul_first_gnt", 32'(gnt), 32'h1);
      guard = 0;
      while (gnt == 2'b01 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      idleCnt = 0;
      while (gnt == 2'b00 && guard < 60) begin
         idleCnt++;
         @(negedge clk);
         guard++;
      end
      checkOutput("handover_idle", 32'(idleCnt), 32'd1);
      checkOutput("handover_gnt", 32'(gnt), 32'h2);
   endtask

   task automatic randomTraffic(input int x, input int nTrans);
      for (int t = 0; t < nTrans; t++) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            #1;
         end
         applyStimulus(x, $urandom_range(1, 3), 32'(x * 256) + 32'(4 * $urandom_range(0, 60)),
                       1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(1, 15)));
      end
   endtask

   task automatic stalledStrobeTest();
      int errAt;
      int errCount;
      slaveHang  = 1'b1;
      errAllowed = 1'b1;
      mAdrI[0] = 32'h20;
      mSelI[0] = 4'hF;
      mWeI[0]  = 1'b0;
      mCycI[0] = 1'b1;
      mStbI[0] = 1'b1;
      errAt    = -1;
      errCount = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (mErr[0]) begin
            errCount++;
            if (errAt < 0) begin
               errAt = k;
               checkOutput("wd_stb_masked", 32'(sStb), 32'd0);
               checkOutput("wd_cyc_masked", 32'(sCyc), 32'd0);
               checkOutput("wd_other_err", 32'(mErr[1]), 32'd0);
            end
         end
      end
`ifdef WB_ARB_TIMEOUT_EN
      checkOutput("wd_first_err_cycle", 32'(errAt), 32'(TIMEOUT));
      checkOutput("wd_err_count", 32'(errCount), 32'(20 / TIMEOUT));
`else
      checkOutput("hang_no_err", 32'(errCount), 32'd0);
      checkOutput("hang_stb_held", 32'(sStb), 32'd1);
`endif
      checkOutput("hang_gnt_held", 32'(gnt), 32'h1);
      #1;
      mCycI[0]  = 1'b0;
      mStbI[0]  = 1'b0;
      slaveHang = 1'b0;
      @(negedge clk);
      #1 errAllowed = 1'b0;
   endtask

   // Main sequence: directed cases first, then randomized concurrent traffic.
   initial begin : mainSeq
      reset = 1'b1;
      for (int i = 0; i < 128; i++) shadow[i] = 32'h0;
      for (int x = 0; x < 2; x++) begin
         mAdrI[x] = 32'hFFFF_0000;
         mDatI[x] = 32'h5555_AAAA;
         mSelI[x] = 4'hF;
         mWeI[x]  = 1'b0;
         mCycI[x] = 1'b0;
         mStbI[x] = 1'b0;
      end
      doReset();

      fixedWait = 2;
      fork
         applyStimulus(0, 1, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
         begin
            @(negedge clk);
            checkOutput("grant_latency", 32'(gnt), 32'h1);
         end
      join
      checkAckOrder("single_write", 1, 8'b0000_0000);
      fixedWait = -1;
      idleCycles(2);

      doReset();
      for (int r = 0; r < 2; r++) begin
         fork
            applyStimulus(0, 1, 32'h24, 1'b1, $urandom(), 4'hF);
            applyStimulus(1, 1, 32'h124, 1'b1, $urandom(), 4'hF);
            watchHandover();
         join
         checkAckOrder("round_robin", 2, 8'b0000_0010);
         idleCycles(1);
      end

      fork
         applyStimulus(1, 3, 32'h130, 1'b1, $urandom(), 4'hF);
         begin
            idleCycles(2);
            applyStimulus(0, 1, 32'h30, 1'b0, 32'h0, 4'hF);
         end
      join
      checkAckOrder("atomic_burst", 4, 8'b0000_0111);
      idleCycles(2);

      applyStimulus(1, 1, 32'h140, 1'b1, 32'h1234_5678, 4'hF);
      idleCycles(1);
      applyStimulus(1, 1, 32'h140, 1'b0, 32'h0, 4'hF);
      checkAckOrder("m1_read", 2, 8'b0000_0011);
      idleCycles(2);

      slaveHang = 1'b1;
      mAdrI[0] = 32'h40;
      mDatI[0] = $urandom();
      mWeI[0]  = 1'b1;
      mCycI[0] = 1'b1;
      mStbI[0] = 1'b1;
      @(negedge clk);
      checkOutput("abort_granted", 32'(gnt), 32'h1);
      #1 reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_gnt", 32'(gnt), 32'd0);
      checkOutput("abort_s_cyc", 32'(sCyc), 32'd0);
      checkOutput("abort_ack", 32'(mAck[0]), 32'd0);
      checkOutput("abort_err", 32'(mErr[0]), 32'd0);
      #1;
      mCycI[0]  = 1'b0;
      mStbI[0]  = 1'b0;
      mWeI[0]   = 1'b0;
      reset     = 1'b0;
      slaveHang = 1'b0;
      checkAckOrder("abort_no_ack", 0, 8'b0000_0000);
      idleCycles(2);

      stalledStrobeTest();
      idleCycles(2);

      fork
         randomTraffic(0, 30);
         randomTraffic(1, 30);
      join
      idleCycles(3);
      checkOutput("q0_drained", 32'(expQ0.size()), 32'd0);
      checkOutput("q1_drained", 32'(expQ1.size()), 32'd0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
